hs_handshake_responder: RTL and testbench
=========================================

Name: hs_handshake_responder

Overview:
- Responder end of the req -> grant -> ack handshake: consumes req, issues a one-cycle grant, then issues a one-cycle ack inside a bounded delay window gated by a backend done signal.
- Defaults produce exactly "req ##1 grant ##2 ack".
- Sits between a requesting initiator and a backend engine.
- Also serves as the synthesizable DUT for the SVA delay-operator suite (##0/##N/##[m:n]/##[1:$]).

Parameters:
- ACK_MIN, 2, minimum cycles from grant to ack; range 1..ACK_MAX when bounded.
- ACK_MAX, 2, maximum cycles from grant to ack; 0 = unbounded (##[ACK_MIN:$]).
- CNT_W, 8, width of delay counter and lat output; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request from initiator; level, sampled only in IDLE.
- done  in  1  backend completion; sampled in WAIT.
- grant  out  1  one-cycle pulse, 1 cycle after req accepted.
- ack  out  1  one-cycle pulse ending the transaction.
- timeout  out  1  one-cycle pulse coincident with ack when ACK_MAX is reached without done.
- busy  out  1  high from grant cycle through ack cycle inclusive.
- lat  out  CNT_W  grant-to-ack delay of the last completed transaction; updated in the ack cycle.

Behaviour:
- Reset: async assert -> state IDLE; grant, ack, timeout, busy = 0; lat = 0; counter = 0; done_seen = 0. Mid-transaction reset aborts with no ack. The first req is accepted at the first edge after deassertion.
- All outputs are registered; no combinational input -> output path.
- States: IDLE, GRANT, WAIT, ACK.
- IDLE: req=1 at edge E -> GRANT. grant=1, busy=1 in cycle E+1 (cycle G). Counter <- 0, done_seen <- 0. req=0 -> stay.
- GRANT (one cycle) -> WAIT. Counter increments every edge while in GRANT/WAIT.
- done_seen sets on any edge in GRANT/WAIT where done=1. It is sticky until the next grant.
- Ack cycle is G+d, where d is the smallest value >= ACK_MIN such that done_seen (including done sampled at edge G+d) holds. done before ACK_MIN is remembered, and ack is held until G+ACK_MIN.
- Bounded case: if d reaches ACK_MAX with no done, ack=1 and timeout=1 at G+ACK_MAX. done sampled at the same edge as that decision counts as done, so no timeout.
- Unbounded case: wait indefinitely. Counter saturates and never wraps; lat reports the saturated value.
- ACK state (the ack cycle): ack=1, busy=1, lat <- d. Next state is IDLE.
- IDLE is occupied for at least one cycle after ack. req still high there is a new request, so a continuously held req gives period d+2: grant at G, ack at G+d, next grant at G+d+2.
- req changes outside IDLE are ignored. done outside GRANT/WAIT is ignored.
- Parameter legality is checked at elaboration: ACK_MIN >= 1; ACK_MAX == 0 or ACK_MAX >= ACK_MIN; ACK_MAX < 2^CNT_W. Violation -> $error.

Decomposition:
- Package hs_resp_pkg:
  - state enum hs_state_e {IDLE, GRANT, WAIT, ACK};
  - localparam function computing the saturation limit.
- Sub-module hs_resp_props: bindable SVA checker carrying the protocol properties:
  - req&&!busy |=> grant;
  - grant |-> ##[ACK_MIN:ACK_MAX] ack, with $ when ACK_MAX is 0;
  - grant |-> !ack, since ACK_MIN >= 1;
  - ack |=> !busy;
  - timeout |-> ack;
  - grant and ack are one-hot pulses.

Test Plan:
- Defaults; req pulse at cycle 5, done held high -> grant at 6, ack at 8, lat=2, timeout never. Property "req ##1 grant ##2 ack" passes.
- ACK_MIN=2, ACK_MAX=5; done pulse at G+3 -> ack at G+3, lat=3. Done pulse at G+1 -> ack at G+2, lat=2.
- ACK_MIN=2, ACK_MAX=5; done never -> ack and timeout both high at G+5, lat=5. Done exactly at G+5 -> ack at G+5, timeout=0.
- ACK_MIN=1, ACK_MAX=0, CNT_W=4; done at G+40 -> ack at G+40, lat=15 (saturated), no timeout.
- Defaults; req held high for 20 cycles -> grants at 1, 5, 9, ..., acks 2 cycles after each, busy low exactly one cycle between transactions.
- rst_n dropped asynchronously mid-WAIT, between edges -> busy, grant, ack, lat go 0 immediately. No ack is issued. A req after release gets grant one cycle later.

Source files
------------

// File: rtl/hs_resp_pkg.sv
// Shared types and helpers for the req -> grant -> ack responder.
package hs_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } hs_state_e;

  // Largest value a w-bit counter can hold before it must saturate.
  function automatic int unsigned sat_limit(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/hs_resp_props.sv
// Protocol checker for the responder: grant/ack ordering, ack delay window, pulse shapes.
module hs_resp_props
  import hs_resp_pkg::*;
#(
  parameter int unsigned ACK_MIN = 2,
  parameter int unsigned ACK_MAX = 2
) (
  input logic clk,
  input logic rst_n,
  input logic req,
  input logic grant,
  input logic ack,
  input logic timeout,
  input logic busy
);

  localparam bit BOUNDED = (ACK_MAX != 0);

  // Cycles since the last grant; gcnt == k in cycle G+k while a transaction is open.
  logic        pending;
  int unsigned gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      gcnt    <= 0;
    end else if (grant) begin
      pending <= 1'b1;
      gcnt    <= 1;
    end else if (ack) begin
      pending <= 1'b0;
    end else if (pending && gcnt != 32'hFFFF_FFFF) begin
      gcnt <= gcnt + 1;
    end
  end

  a_req_grant : assert property (@(posedge clk) disable iff (!rst_n)
    req && !busy |=> grant);

  a_ack_window : assert property (@(posedge clk) disable iff (!rst_n)
    ack |-> pending && gcnt >= ACK_MIN && (!BOUNDED || gcnt <= ACK_MAX));

  a_ack_deadline : assert property (@(posedge clk) disable iff (!rst_n)
    pending && BOUNDED |-> gcnt <= ACK_MAX);

  a_grant_no_ack : assert property (@(posedge clk) disable iff (!rst_n)
    grant |-> !ack);

  a_ack_idle : assert property (@(posedge clk) disable iff (!rst_n)
    ack |=> !busy);

  a_timeout_ack : assert property (@(posedge clk) disable iff (!rst_n)
    timeout |-> ack);

  a_grant_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    grant |=> !grant);

  a_ack_pulse : assert property (@(posedge clk) disable iff (!rst_n)
    ack |=> !ack);

endmodule

// File: rtl/hs_handshake_responder.sv
// Responder end of the req -> grant -> ack handshake with a bounded, done-gated ack window.
// State | meaning: IDLE wait for req | GRANT grant pulse | WAIT count, collect done | ACK ack pulse, latch lat
module hs_handshake_responder
  import hs_resp_pkg::*;
#(
  parameter int unsigned ACK_MIN = 2,
  parameter int unsigned ACK_MAX = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             done,
  output logic             grant,
  output logic             ack,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] lat
);

  localparam int unsigned      SAT     = sat_limit(CNT_W);
  localparam logic [CNT_W-1:0] CNT_SAT = SAT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MIN_C   = ACK_MIN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] MAX_C   = ACK_MAX[CNT_W-1:0];
  localparam bit               BOUNDED = (ACK_MAX != 0);

  if (ACK_MIN < 1) begin : g_bad_min
    $error("hs_handshake_responder: ACK_MIN must be at least 1");
  end
  if (BOUNDED && ACK_MAX < ACK_MIN) begin : g_bad_max
    $error("hs_handshake_responder: ACK_MAX must be 0 or >= ACK_MIN");
  end
  if (ACK_MAX > SAT) begin : g_bad_width
    $error("hs_handshake_responder: ACK_MAX does not fit in CNT_W bits");
  end

  hs_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             done_seen, seen_nxt, done_eff;
  logic             timeout_nxt;
  logic [CNT_W-1:0] lat_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      done_seen <= 1'b0;
      timeout   <= 1'b0;
      lat       <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      done_seen <= seen_nxt;
      timeout   <= timeout_nxt;
      lat       <= lat_nxt;
    end
  end

  // cnt_inc is the delay d the ack would have if it landed on this edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    seen_nxt    = done_seen;
    timeout_nxt = 1'b0;
    lat_nxt     = lat;
    cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
    done_eff    = done_seen | done;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = GRANT;
          cnt_nxt   = '0;
          seen_nxt  = 1'b0;
        end
      end
      GRANT, WAIT: begin
        cnt_nxt  = cnt_inc;
        seen_nxt = done_eff;
        if (done_eff && cnt_inc >= MIN_C) begin
          state_nxt = ACK;
          lat_nxt   = cnt_inc;
        end else if (BOUNDED && cnt_inc == MAX_C) begin
          state_nxt   = ACK;
          lat_nxt     = cnt_inc;
          timeout_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded straight from the state register, so every output is flop-driven.
  assign grant = (state == GRANT);
  assign ack   = (state == ACK);
  assign busy  = (state != IDLE);

  hs_resp_props #(
    .ACK_MIN (ACK_MIN),
    .ACK_MAX (ACK_MAX)
  ) u_props (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .ack     (ack),
    .timeout (timeout),
    .busy    (busy)
  );

endmodule

// File: tb/tb_hs_handshake_responder.sv
// Directed bench: three responder configurations driven from a vector table plus corner sequences.
module tb_hs_handshake_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_v;
  logic [2:0] done_v;
  logic [2:0] grant_v;
  logic [2:0] ack_v;
  logic [2:0] to_v;
  logic [2:0] busy_v;
  logic [7:0] lat_a;
  logic [7:0] lat_b;
  logic [3:0] lat_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // inst 0: defaults (2,2,8); inst 1: (2,5,8); inst 2: (1,unbounded,4)
  hs_handshake_responder u_a (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .done(done_v[0]),
    .grant(grant_v[0]), .ack(ack_v[0]), .timeout(to_v[0]), .busy(busy_v[0]), .lat(lat_a));

  hs_handshake_responder #(.ACK_MIN(2), .ACK_MAX(5), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .done(done_v[1]),
    .grant(grant_v[1]), .ack(ack_v[1]), .timeout(to_v[1]), .busy(busy_v[1]), .lat(lat_b));

  hs_handshake_responder #(.ACK_MIN(1), .ACK_MAX(0), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .done(done_v[2]),
    .grant(grant_v[2]), .ack(ack_v[2]), .timeout(to_v[2]), .busy(busy_v[2]), .lat(lat_c));

  typedef struct {
    int inst;
    int done_at;   // -1: done held high; 0: never; k: sampled at edge G+k
    int exp_d;
    int exp_to;
    int exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    case (i)
      0:       return int'(lat_a);
      1:       return int'(lat_b);
      default: return int'(lat_c);
    endcase
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int    d;
    int    to_at;
    int    lat_at;
    string tag;
    d      = -1;
    to_at  = -1;
    lat_at = -1;
    tag    = $sformatf("vec%0d", idx);
    @(negedge clk);
    req_v[v.inst] = 1'b1;
    @(negedge clk);
    req_v[v.inst] = 1'b0;
    check({tag, "_grant"}, int'(grant_v[v.inst]), 1);
    for (int k = 1; k <= 60; k++) begin
      done_v[v.inst] = (v.done_at < 0) || (v.done_at == k);
      @(negedge clk);
      if (ack_v[v.inst]) begin
        d      = k;
        to_at  = int'(to_v[v.inst]);
        lat_at = lat_of(v.inst);
        break;
      end
    end
    done_v[v.inst] = 1'b0;
    check({tag, "_ack_delay"}, d, v.exp_d);
    check({tag, "_timeout"}, to_at, v.exp_to);
    check({tag, "_lat"}, lat_at, v.exp_lat);
    @(negedge clk);
    check({tag, "_busy_after"}, int'(busy_v[v.inst]), 0);
  endtask

  initial begin
    int d;
    vecs[0]  = '{0, -1, 2, 0, 2};
    vecs[1]  = '{0,  1, 2, 0, 2};
    vecs[2]  = '{0,  0, 2, 1, 2};
    vecs[3]  = '{1,  3, 3, 0, 3};
    vecs[4]  = '{1,  1, 2, 0, 2};
    vecs[5]  = '{1,  0, 5, 1, 5};
    vecs[6]  = '{1,  5, 5, 0, 5};
    vecs[7]  = '{1,  4, 4, 0, 4};
    vecs[8]  = '{2, 40, 40, 0, 15};
    vecs[9]  = '{2,  1, 1, 0, 1};
    vecs[10] = '{2, 15, 15, 0, 15};
    vecs[11] = '{2, 16, 16, 0, 15};
    vecs[12] = '{2, 14, 14, 0, 14};

    rst_n  = 1'b0;
    req_v  = '0;
    done_v = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_grant", int'(grant_v), 0);
    check("reset_ack", int'(ack_v), 0);
    check("reset_timeout", int'(to_v), 0);
    check("reset_busy", int'(busy_v), 0);
    check("reset_lat", lat_of(0) + lat_of(1) + lat_of(2), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Continuously held req on the default instance: period 4, one idle cycle between.
    @(negedge clk);
    req_v[0]  = 1'b1;
    done_v[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("held_c%0d", c), int'({grant_v[0], ack_v[0], busy_v[0]}),
            int'({c % 4 == 1, c % 4 == 3, c % 4 != 0}));
    end
    req_v[0]  = 1'b0;
    done_v[0] = 1'b0;
    @(negedge clk);
    check("held_stop", int'(busy_v[0]), 0);

    // Asynchronous reset in the middle of WAIT on instance 1.
    @(negedge clk);
    req_v[1] = 1'b1;
    @(negedge clk);
    req_v[1] = 1'b0;
    check("rst_mid_grant", int'(grant_v[1]), 1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_waiting", int'(busy_v[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy_v), 0);
    check("rst_mid_grant0", int'(grant_v), 0);
    check("rst_mid_lat", lat_of(1), 0);
    @(negedge clk);
    check("rst_mid_no_ack", int'(ack_v), 0);
    req_v[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_v[1] = 1'b0;
    check("rst_release_grant", int'(grant_v[1]), 1);
    d = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ack_v[1]) begin
        d = k;
        break;
      end
    end
    check("rst_release_ack", d, 5);
    check("rst_release_lat", lat_of(1), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
